// File: rtl/icache_refill_unit_if.sv
// rtl/icache_refill_unit_if.sv - icache refill request and DRAM word-read bundle
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

interface icache_refill_unit_if #(
  parameter int ADDR_W      = `DRAM_ADDRESS_SIZE,
  parameter int WORD_W      = `DRAM_WORD_SIZE,
  parameter int BLOCK_WORDS = `DRAM_BLOCK_SIZE
);
  logic [ADDR_W-1:0]                   mem_address;
  logic                                mem_valid;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  mem_data;
  logic                                mem_ready;
  logic [ADDR_W-1:0]                   dram_addr;
  logic                                dram_req;
  logic [WORD_W-1:0]                   dram_rdata;
  logic                                dram_ack;
  logic                                busy;

  modport slave (
    input  mem_address, mem_valid, dram_rdata, dram_ack,
    output mem_data, mem_ready, dram_addr, dram_req, busy
  );

  modport master (
    output mem_address, mem_valid, dram_rdata, dram_ack,
    input  mem_data, mem_ready, dram_addr, dram_req, busy
  );
endinterface

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - fetches one cache block word by word from DRAM
// Abortable refill: a new request mid-block drains the outstanding word, then restarts.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

module icache_refill_unit #(
  parameter int ADDR_W      = `DRAM_ADDRESS_SIZE,
  parameter int WORD_W      = `DRAM_WORD_SIZE,
  parameter int BLOCK_WORDS = `DRAM_BLOCK_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  icache_refill_unit_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [ADDR_W-1:0]                  base_q, base_d;
  logic [ADDR_W-1:0]                  pend_q, pend_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] buf_q, buf_d;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] data_q, data_d;
  logic                               ready_q, ready_d;
  logic                               req_q, req_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic                               busy_q;

  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] start_base;
  logic [CNT_W-1:0]  cnt_inc;

  assign req_base   = bus.mem_address & ~OFF_MASK;
  // A request seen this edge always beats an older pending one.
  assign start_base = bus.mem_valid ? req_base : pend_q;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    data_d  = data_q;
    ready_d = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, DONE: begin
        req_d   = 1'b0;
        state_d = IDLE;
        if (bus.mem_valid) begin
          base_d  = start_base;
          cnt_d   = '0;
          addr_d  = start_base;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.dram_ack && bus.mem_valid) begin
          base_d = start_base;
          cnt_d  = '0;
          addr_d = start_base;
        end else if (bus.dram_ack) begin
          buf_d[cnt_q] = bus.dram_rdata;
          if (cnt_q == LAST_CNT) begin
            data_d  = buf_d;
            ready_d = 1'b1;
            req_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d  = cnt_inc;
            addr_d = base_q | ADDR_W'({cnt_inc, 2'b00});
          end
        end else if (bus.mem_valid) begin
          pend_d  = req_base;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.dram_ack) begin
          base_d  = start_base;
          pend_d  = '0;
          cnt_d   = '0;
          addr_d  = start_base;
          state_d = FETCH;
        end else if (bus.mem_valid) begin
          pend_d = req_base;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.mem_data  = data_q;
  assign bus.mem_ready = ready_q;
  assign bus.dram_req  = req_q;
  assign bus.dram_addr = addr_q;
  assign bus.busy      = busy_q;
endmodule
